ifmap_row_tagger: RTL

Transmit-side encoder for the tagged IFmap stream consumed by `design_top`'s IF buffer. It takes raw 16-bit feature-map samples over a valid/ready interface and frames them into rows of a programmed length. It emits 18-bit words on the `IF_wen`/`IF_din` write port, with start-of-row and end-of-row tags, and obeys `IF_full` backpressure. It sits between the host/DMA sample source and `design_top`, and replaces hand-built tag patterns.

---
 rtl/ifmap_row_tagger.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ifmap_row_tagger.sv
// ifmap_row_tagger: frames raw feature-map samples into tagged rows for the IF buffer.
// Ports: clk/rst; start+row_len+row_cnt launch a frame; in_valid/in_data/in_ready
//   sample input; IF_full/IF_wen/IF_din buffer write port; busy/done frame status.
module ifmap_row_tagger #(
    parameter int IF_SCRATCH_WIDTH = 16,
    parameter int ROW_LEN_BITS     = 8,
    parameter int ROW_CNT_BITS     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ROW_LEN_BITS-1:0]     row_len,
    input  logic [ROW_CNT_BITS-1:0]     row_cnt,
    input  logic                        in_valid,
    input  logic [IF_SCRATCH_WIDTH-1:0] in_data,
    output logic                        in_ready,
    input  logic                        IF_full,
    output logic                        IF_wen,
    output logic [IF_SCRATCH_WIDTH+1:0] IF_din,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [ROW_LEN_BITS-1:0]     col_q, col_d;
    logic [ROW_CNT_BITS-1:0]     row_q, row_d;
    logic [ROW_LEN_BITS-1:0]     len_q, len_d;
    logic [ROW_CNT_BITS-1:0]     cnt_q, cnt_d;
    logic                        out_vld_q, out_vld_d;
    logic [IF_SCRATCH_WIDTH+1:0] din_q, din_d;

    logic col_last;
    logic row_last;
    logic accept;

    assign col_last = (col_q == len_q - ROW_LEN_BITS'(1));
    assign row_last = (row_q == cnt_q - ROW_CNT_BITS'(1));

    // A write is never issued into a full buffer.
    assign IF_wen   = out_vld_q & ~IF_full;
    // The output register can take a new word if empty or draining this cycle.
    assign in_ready = (state_q == STREAM) & (~out_vld_q | ~IF_full);
    assign accept   = in_valid & in_ready;
    assign IF_din   = din_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FLUSH) & IF_wen;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            out_vld_q <= 1'b0;
            din_q     <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            out_vld_q <= out_vld_d;
            din_q     <= din_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        out_vld_d = out_vld_q;
        din_d     = din_q;

        // Drain first; a same-cycle accept below reloads the register.
        if (IF_wen) begin
            out_vld_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start && (row_len != '0) && (row_cnt != '0)) begin
                    len_d   = row_len;
                    cnt_d   = row_cnt;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    din_d     = {(col_q == '0), col_last, in_data};
                    out_vld_d = 1'b1;
                    if (col_last) begin
                        col_d = '0;
                        if (row_last) begin
                            row_d   = '0;
                            state_d = FLUSH;
                        end else begin
                            row_d = row_q + ROW_CNT_BITS'(1);
                        end
                    end else begin
                        col_d = col_q + ROW_LEN_BITS'(1);
                    end
                end
            end
            FLUSH: begin
                if (IF_wen) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
